// File: rtl/lut_seq_pkg.sv
// Shared types and helpers for the LUT layer sequencer: FSM state encoding,
// default fan-in and the neuron table-address builder.
package lut_seq_pkg;

  localparam int FANIN_DEF = 8;

  // Upper bounds for the padded operands handed to lut_addr().
  localparam int MAX_IN_W  = 1024;
  localparam int MAX_IDX_W = 10;
  localparam int MAX_FANIN = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  // Slot i of the address is the capture bit selected by connection i;
  // an index past the real vector width falls back to capture bit 0.
  function automatic logic [MAX_FANIN-1:0] lut_addr(
    input logic [MAX_IN_W-1:0]                  cap,
    input int unsigned                          in_w,
    input logic [MAX_FANIN-1:0][MAX_IDX_W-1:0]  row
  );
    logic [MAX_FANIN-1:0] a;
    a = '0;
    for (int i = 0; i < MAX_FANIN; i++) begin
      a[i] = (32'(row[i]) < in_w) ? cap[row[i]] : cap[0];
    end
    return a;
  endfunction

endpackage

// File: rtl/lut_table_mem.sv
// Truth-table store for all neurons of the layer: one write port and one
// registered read port, both addressed by {neuron, table address}.
module lut_table_mem #(
  parameter int FANIN = 8,
  parameter int NID_W = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [NID_W-1:0] wnid_i,
  input  logic [FANIN-1:0] waddr_i,
  input  logic             wbit_i,
  input  logic             re_i,
  input  logic [NID_W-1:0] rnid_i,
  input  logic [FANIN-1:0] raddr_i,
  output logic             rdata_o
);

  localparam int DEPTH = 2 ** (NID_W + FANIN);

  logic mem_q [DEPTH];
  logic rdata_q;

  // Contents are configuration data and deliberately carry no reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wnid_i, waddr_i}] <= wbit_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[{rnid_i, raddr_i}];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed evaluator for one layer of fan-in-N truth-table neurons.
// Optional perf counters are built when LUT_SEQ_PERF_EN is defined.
module lut_layer_sequencer
  import lut_seq_pkg::*;
#(
  parameter int IN_W    = 64,
  parameter int NEURONS = 16,
  parameter int FANIN   = FANIN_DEF,
  parameter int IDX_W   = (IN_W > 1) ? $clog2(IN_W) : 1,
  parameter int NID_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NEURONS-1:0] out_data,
  output logic               cfg_ready,
  input  logic               cfg_tbl_we,
  input  logic               cfg_conn_we,
  input  logic [NID_W-1:0]   cfg_neuron,
  input  logic [FANIN-1:0]   cfg_addr,
  input  logic [IDX_W-1:0]   cfg_wdata,
  output logic               busy
`ifdef LUT_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_vectors,
  output logic [31:0]        perf_stall
`endif
);

  localparam int SLOT_W = (FANIN > 1) ? $clog2(FANIN) : 1;

  seq_state_e         state_q, state_d;
  logic [NID_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]    cap_q, cap_d;
  logic [NEURONS-1:0] out_q, out_d;
  logic               rd_vld_q, rd_vld_d;
  logic [NID_W-1:0]   rd_nid_q, rd_nid_d;

  logic [IDX_W-1:0]   conn_q [NEURONS][FANIN];

  logic               accept;
  logic               out_fire;
  logic               rd_issue;
  logic               last_nrn;
  logic               rd_bit;
  logic               tbl_we;
  logic               conn_we;
  logic [SLOT_W-1:0]  cfg_slot;
  logic [FANIN-1:0]   rd_addr;

  logic [MAX_IN_W-1:0]                 cap_pad;
  logic [MAX_FANIN-1:0][MAX_IDX_W-1:0] row_pad;

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; once raised, out_valid and out_data hold until taken.
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign last_nrn = (cnt_q == NID_W'(NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_valid)  state_d = ST_EVAL;
      ST_EVAL:  if (last_nrn)  state_d = ST_DRAIN;
      ST_DRAIN:                state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    cfg_ready = (state_q == ST_IDLE);
    out_valid = (state_q == ST_HOLD);
    busy      = (state_q == ST_EVAL) || (state_q == ST_DRAIN);
    rd_issue  = (state_q == ST_EVAL);
  end

  // Config storage only changes while idle, so an evaluation never sees a
  // half-updated neuron; a write in the accept cycle is visible to it.
  assign tbl_we   = cfg_tbl_we & cfg_ready;
  assign cfg_slot = cfg_addr[SLOT_W-1:0];
  assign conn_we  = cfg_conn_we & cfg_ready
                  & (32'(cfg_neuron) < 32'(NEURONS))
                  & (32'(cfg_slot) < 32'(FANIN));

  always_ff @(posedge clk) begin
    if (conn_we) begin
      conn_q[cfg_neuron][cfg_slot] <= cfg_wdata;
    end
  end

  always_comb begin
    cap_pad = MAX_IN_W'(cap_q);
    row_pad = '0;
    for (int i = 0; i < FANIN; i++) begin
      row_pad[i] = MAX_IDX_W'(conn_q[cnt_q][i]);
    end
    rd_addr = FANIN'(lut_addr(cap_pad, IN_W, row_pad));
  end

  lut_table_mem #(
    .FANIN (FANIN),
    .NID_W (NID_W)
  ) u_tbl (
    .clk     (clk),
    .we_i    (tbl_we),
    .wnid_i  (cfg_neuron),
    .waddr_i (cfg_addr),
    .wbit_i  (cfg_wdata[0]),
    .re_i    (rd_issue),
    .rnid_i  (cnt_q),
    .raddr_i (rd_addr),
    .rdata_o (rd_bit)
  );

  always_comb begin
    cap_d    = accept ? in_data : cap_q;
    cnt_d    = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (rd_issue) begin
      cnt_d = last_nrn ? '0 : cnt_q + 1'b1;
    end
    rd_vld_d = rd_issue;
    rd_nid_d = cnt_q;
    out_d    = out_q;
    // Each read result lands one cycle after issue, into its neuron's bit.
    if (rd_vld_q) begin
      out_d[rd_nid_q] = rd_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      cap_q    <= '0;
      out_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_nid_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      out_q    <= out_d;
      rd_vld_q <= rd_vld_d;
      rd_nid_q <= rd_nid_d;
    end
  end

  assign out_data = out_q;

`ifdef LUT_SEQ_PERF_EN
  logic [31:0] perf_vec_q, perf_vec_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_vec_d   = perf_vec_q;
    perf_stall_d = perf_stall_q;
    if (out_fire && (perf_vec_q != '1)) begin
      perf_vec_d = perf_vec_q + 32'd1;
    end
    if ((state_q == ST_HOLD) && !out_ready && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_vec_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_vec_q   <= perf_vec_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_vectors = perf_vec_q;
  assign perf_stall   = perf_stall_q;
`else
  logic unused_fire;
  assign unused_fire = out_fire;
`endif

endmodule
